// File: rtl/div_pkg.sv
// Shared types and widths for the 64/32 unsigned divider.
package div_pkg;
    localparam int DIVIDEND_W = 64;
    localparam int DIVISOR_W  = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
import div_pkg::*;

module div_step (
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] new_rem,
    output logic                 q_bit
);
    logic [DIVISOR_W:0] partial;

    assign partial = {rem, dividend_bit};
    assign q_bit   = (partial >= {1'b0, divisor});
    // rem < divisor, so partial - divisor always fits DIVISOR_W bits
    assign new_rem = q_bit ? DIVISOR_W'(partial - {1'b0, divisor})
                           : partial[DIVISOR_W-1:0];
endmodule

// File: rtl/div64x32.sv
// Multi-cycle 64/32 unsigned restoring divider, one quotient bit per clock.
import div_pkg::*;

module div64x32 (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    div_step u_step (
        .rem         (rem),
        .dividend_bit(dvd[DIVIDEND_W-1]),
        .divisor     (dvs),
        .new_rem     (step_rem),
        .q_bit       (step_q)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start)
                    next_state = (divisor == '0) ? ZERO : RUN;
            end
            RUN: begin
                if (cnt == '0)
                    next_state = IDLE;
            end
            ZERO:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= dividend;
                        dvs <= divisor;
                        rem <= '0;
                        quo <= '0;
                        cnt <= (divisor != '0) ? CNT_W'(63) : '0;
                    end
                end
                RUN: begin
                    dvd <= dvd << 1;
                    rem <= step_rem;
                    quo <= {quo[DIVIDEND_W-2:0], step_q};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        quotient    <= {quo[DIVIDEND_W-2:0], step_q};
                        remainder   <= step_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= dvd[DIVISOR_W-1:0];
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
